// File: rtl/traffic_junction.sv
// traffic_junction: round-robin N-approach traffic-light sequencer.
// Define PED_CROSSING_EN to add the latched pedestrian walk phase.
module traffic_junction #(
    parameter int NUM_APPROACH  = 2,
    parameter int ALL_RED_CYC   = 2,
    parameter int RED_AMBER_CYC = 2,
    parameter int GREEN_CYC     = 8,
    parameter int AMBER_CYC     = 3,
    parameter int PED_CYC       = 4,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    ped_req,
    output logic [NUM_APPROACH-1:0] red,
    output logic [NUM_APPROACH-1:0] amber,
    output logic [NUM_APPROACH-1:0] green,
    output logic [1:0]              active,
    output logic                    ped_walk
);

    localparam logic [2:0] ALL_RED   = 3'd0;
    localparam logic [2:0] RED_AMBER = 3'd1;
    localparam logic [2:0] GREEN     = 3'd2;
    localparam logic [2:0] AMBER     = 3'd3;

    localparam logic [1:0] LAST_APP = 2'(NUM_APPROACH - 1);

    // Timer holds remaining cycles minus one; zero means this is the last cycle.
    localparam logic [CNT_W-1:0] LD_ALL_RED   = CNT_W'(ALL_RED_CYC - 1);
    localparam logic [CNT_W-1:0] LD_RED_AMBER = CNT_W'(RED_AMBER_CYC - 1);
    localparam logic [CNT_W-1:0] LD_GREEN     = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_AMBER     = CNT_W'(AMBER_CYC - 1);

`ifdef PED_CROSSING_EN
    localparam logic [2:0]       PED_WALK = 3'd4;
    localparam logic [CNT_W-1:0] LD_PED   = CNT_W'(PED_CYC - 1);
`else
    localparam int PED_CYC_UNUSED = PED_CYC;
`endif

    logic [2:0]              state;
    logic [2:0]              state_nx;
    logic [CNT_W-1:0]        timer;
    logic [CNT_W-1:0]        timer_nx;
    logic [1:0]              active_nx;
    logic [NUM_APPROACH-1:0] red_nx;
    logic [NUM_APPROACH-1:0] amber_nx;
    logic [NUM_APPROACH-1:0] green_nx;
    logic                    last_cyc;

    assign last_cyc = (timer == '0);

`ifdef PED_CROSSING_EN
    logic ped_pending;
    logic pending_nx;
    logic ped_go;

    assign ped_go = ped_pending | ped_req;

    // A request that starts the walk is consumed; requests during the walk are dropped.
    always_comb begin
        pending_nx = ped_pending;
        if (state == ALL_RED && last_cyc && ped_go) begin
            pending_nx = 1'b0;
        end else if (state != PED_WALK && ped_req) begin
            pending_nx = 1'b1;
        end
    end
`else
    logic ped_req_unused;
    assign ped_req_unused = ped_req;
`endif

    always_comb begin
        state_nx  = state;
        timer_nx  = timer - CNT_W'(1);
        active_nx = active;
        if (last_cyc) begin
            case (state)
                ALL_RED: begin
`ifdef PED_CROSSING_EN
                    if (ped_go) begin
                        state_nx = PED_WALK;
                        timer_nx = LD_PED;
                    end else
`endif
                    begin
                        state_nx = RED_AMBER;
                        timer_nx = LD_RED_AMBER;
                    end
                end
                RED_AMBER: begin
                    state_nx = GREEN;
                    timer_nx = LD_GREEN;
                end
                GREEN: begin
                    state_nx = AMBER;
                    timer_nx = LD_AMBER;
                end
                AMBER: begin
                    state_nx  = ALL_RED;
                    timer_nx  = LD_ALL_RED;
                    active_nx = (active == LAST_APP) ? 2'd0 : active + 2'd1;
                end
`ifdef PED_CROSSING_EN
                PED_WALK: begin
                    state_nx = RED_AMBER;
                    timer_nx = LD_RED_AMBER;
                end
`endif
                default: begin
                    state_nx = ALL_RED;
                    timer_nx = LD_ALL_RED;
                end
            endcase
        end
    end

    // Lamps are decoded from the next state so they register alongside it.
    always_comb begin
        red_nx   = '1;
        amber_nx = '0;
        green_nx = '0;
        for (int i = 0; i < NUM_APPROACH; i++) begin
            if (active_nx == 2'(i)) begin
                unique case (1'b1)
                    state_nx == RED_AMBER: begin
                        amber_nx[i] = 1'b1;
                    end
                    state_nx == GREEN: begin
                        red_nx[i]   = 1'b0;
                        green_nx[i] = 1'b1;
                    end
                    state_nx == AMBER: begin
                        red_nx[i]   = 1'b0;
                        amber_nx[i] = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ALL_RED;
            timer  <= LD_ALL_RED;
            active <= 2'd0;
            red    <= '1;
            amber  <= '0;
            green  <= '0;
        end else if (enable) begin
            state  <= state_nx;
            timer  <= timer_nx;
            active <= active_nx;
            red    <= red_nx;
            amber  <= amber_nx;
            green  <= green_nx;
        end
    end

`ifdef PED_CROSSING_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pending <= 1'b0;
            ped_walk    <= 1'b0;
        end else if (enable) begin
            ped_pending <= pending_nx;
            ped_walk    <= (state_nx == PED_WALK);
        end
    end
`else
    assign ped_walk = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_junction.sv
// tb_traffic_junction: vector table and sequences on N=2, random run
// against a schedule model on N=3.
module tb_traffic_junction;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       pr  = 1'b0;
    logic [1:0] red2, amber2, green2, act2;
    logic       walk2;

    logic       rst3 = 1'b1;
    logic       en3  = 1'b0;
    logic       pr3  = 1'b0;
    logic [2:0] red3, amber3, green3;
    logic [1:0] act3;
    logic       walk3;

    traffic_junction #(.NUM_APPROACH(2)) d2 (
        .clk(clk), .rst(rst), .enable(en), .ped_req(pr),
        .red(red2), .amber(amber2), .green(green2),
        .active(act2), .ped_walk(walk2)
    );

    traffic_junction #(.NUM_APPROACH(3)) d3 (
        .clk(clk), .rst(rst3), .enable(en3), .ped_req(pr3),
        .red(red3), .amber(amber3), .green(green3),
        .active(act3), .ped_walk(walk3)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       r, e, p;
        logic [1:0] rd, am, gr, ac;
        logic       w;
    } vec_t;

    vec_t tbl[$];

    task automatic add(int n, logic r, logic e, logic p,
                       logic [1:0] rd, logic [1:0] am, logic [1:0] gr,
                       logic [1:0] ac, logic w);
        vec_t v;
        v.r = r; v.e = e; v.p = p;
        v.rd = rd; v.am = am; v.gr = gr; v.ac = ac; v.w = w;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic chk2(string tag, logic [1:0] rd, logic [1:0] am,
                        logic [1:0] gr, logic [1:0] ac, logic w);
        n_chk++;
        if ({red2, amber2, green2, act2, walk2} !== {rd, am, gr, ac, w}) begin
            n_fail++;
            $display("FAIL %s: got r=%b a=%b g=%b act=%0d walk=%b, want r=%b a=%b g=%b act=%0d walk=%b",
                     tag, red2, amber2, green2, act2, walk2, rd, am, gr, ac, w);
        end
    endtask

    task automatic step2(logic r, logic e, logic p);
        rst = r; en = e; pr = p;
        @(posedge clk);
        #1;
    endtask

    task automatic seg(string tag, int n, logic r, logic e, logic p,
                       logic [1:0] rd, logic [1:0] am, logic [1:0] gr,
                       logic [1:0] ac, logic w);
        repeat (n) begin
            step2(r, e, p);
            chk2(tag, rd, am, gr, ac, w);
        end
    endtask

    // Schedule model: position within the current approach slot.
    localparam int AR  = 2;
    localparam int RA  = 2;
    localparam int GC  = 8;
    localparam int AMC = 3;
    localparam int PC  = 4;
`ifdef PED_CROSSING_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    int pos  = 0;
    int slot = 0;
    bit pend = 1'b0;
    bit walk_slot = 1'b0;

    task automatic model_edge(bit r, bit e, bit p);
        bit in_walk;
        if (r) begin
            pos = 0; slot = 0; pend = 1'b0; walk_slot = 1'b0;
        end else if (e) begin
            in_walk = walk_slot && pos >= AR && pos < AR + PC;
            if (PED_EN) begin
                if (pos == AR - 1) begin
                    if (pend || p) begin
                        walk_slot = 1'b1;
                        pend = 1'b0;
                    end
                end else if (p && !in_walk) begin
                    pend = 1'b1;
                end
            end
            pos++;
            if (pos == AR + RA + GC + AMC + (walk_slot ? PC : 0)) begin
                pos = 0;
                slot++;
                walk_slot = 1'b0;
            end
        end
    endtask

    task automatic chk3();
        logic [2:0] er, ea, eg;
        logic [1:0] eact;
        logic       ew;
        int         p, a;
        er = '1; ea = '0; eg = '0; ew = 1'b0;
        a = slot % 3;
        eact = 2'(a);
        p = pos;
        if (p >= AR) begin
            p -= AR;
            if (walk_slot) begin
                if (p < PC) ew = 1'b1;
                p -= PC;
            end
            if (!ew) begin
                if (p < RA) begin
                    ea[a] = 1'b1;
                end else if (p < RA + GC) begin
                    er[a] = 1'b0;
                    eg[a] = 1'b1;
                end else begin
                    er[a] = 1'b0;
                    ea[a] = 1'b1;
                end
            end
        end
        n_chk++;
        if ({red3, amber3, green3, act3, walk3} !== {er, ea, eg, eact, ew}) begin
            n_fail++;
            $display("FAIL rand3 pos=%0d slot=%0d: got r=%b a=%b g=%b act=%0d walk=%b, want r=%b a=%b g=%b act=%0d walk=%b",
                     pos, slot, red3, amber3, green3, act3, walk3, er, ea, eg, eact, ew);
        end
        n_chk++;
        if ($countones(green3) > 1 || (green3 & amber3) != 3'b0 ||
            (walk3 && (green3 != 3'b0 || amber3 != 3'b0))) begin
            n_fail++;
            $display("FAIL invariant3: got g=%b a=%b walk=%b, want one-hot-or-zero green, no green&amber, walk implies dark",
                     green3, amber3, walk3);
        end
    endtask

    initial begin
        // Reset, first full junction period, then a 5-cycle freeze mid-green.
        add(3, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        add(1, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        add(2, 0, 1, 0, 2'b11, 2'b01, 2'b00, 2'd0, 0);
        add(8, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'd0, 0);
        add(3, 0, 1, 0, 2'b10, 2'b01, 2'b00, 2'd0, 0);
        add(2, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd1, 0);
        add(2, 0, 1, 0, 2'b11, 2'b10, 2'b00, 2'd1, 0);
        add(8, 0, 1, 0, 2'b01, 2'b00, 2'b10, 2'd1, 0);
        add(3, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'd1, 0);
        add(2, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        add(2, 0, 1, 0, 2'b11, 2'b01, 2'b00, 2'd0, 0);
        add(3, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'd0, 0);
        add(5, 0, 0, 0, 2'b10, 2'b00, 2'b01, 2'd0, 0);
        add(5, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'd0, 0);
        add(3, 0, 1, 0, 2'b10, 2'b01, 2'b00, 2'd0, 0);
        add(2, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd1, 0);

        foreach (tbl[i]) begin
            step2(tbl[i].r, tbl[i].e, tbl[i].p);
            chk2($sformatf("vec%0d", i), tbl[i].rd, tbl[i].am,
                 tbl[i].gr, tbl[i].ac, tbl[i].w);
        end

`ifdef PED_CROSSING_EN
        // Latched request from approach 0 green walks in approach 1's slot.
        seg("p_rst", 1, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        seg("p_ar0", 1, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        seg("p_ra0", 2, 0, 1, 0, 2'b11, 2'b01, 2'b00, 2'd0, 0);
        seg("p_g0", 1, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'd0, 0);
        seg("p_g0req", 1, 0, 1, 1, 2'b10, 2'b00, 2'b01, 2'd0, 0);
        seg("p_g0", 6, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'd0, 0);
        seg("p_a0", 3, 0, 1, 0, 2'b10, 2'b01, 2'b00, 2'd0, 0);
        seg("p_ar1", 2, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd1, 0);
        seg("p_walk", 4, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd1, 1);
        seg("p_ra1", 2, 0, 1, 0, 2'b11, 2'b10, 2'b00, 2'd1, 0);
        seg("p_g1", 8, 0, 1, 0, 2'b01, 2'b00, 2'b10, 2'd1, 0);
        seg("p_a1", 3, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'd1, 0);
        seg("p_ar0", 2, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        seg("p_ra0_nowalk", 2, 0, 1, 0, 2'b11, 2'b01, 2'b00, 2'd0, 0);
        seg("p_g0", 8, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'd0, 0);
        seg("p_a0", 3, 0, 1, 0, 2'b10, 2'b01, 2'b00, 2'd0, 0);
        seg("p_ar1", 2, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd1, 0);
        // Request only on the edge that ends all-red, then again mid-walk.
        seg("p_walk_last", 1, 0, 1, 1, 2'b11, 2'b00, 2'b00, 2'd1, 1);
        seg("p_walk_req", 1, 0, 1, 1, 2'b11, 2'b00, 2'b00, 2'd1, 1);
        seg("p_walk", 2, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd1, 1);
        seg("p_ra1", 2, 0, 1, 0, 2'b11, 2'b10, 2'b00, 2'd1, 0);
        seg("p_g1", 8, 0, 1, 0, 2'b01, 2'b00, 2'b10, 2'd1, 0);
        seg("p_a1", 3, 0, 1, 0, 2'b01, 2'b10, 2'b00, 2'd1, 0);
        seg("p_ar0", 2, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        seg("p_ra0_nowalk2", 2, 0, 1, 0, 2'b11, 2'b01, 2'b00, 2'd0, 0);
`else
        // Without the crossing feature a held request changes nothing.
        seg("n_rst", 1, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        seg("n_ar0", 1, 0, 1, 1, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        seg("n_ra0", 2, 0, 1, 1, 2'b11, 2'b01, 2'b00, 2'd0, 0);
        seg("n_g0", 8, 0, 1, 1, 2'b10, 2'b00, 2'b01, 2'd0, 0);
        seg("n_a0", 3, 0, 1, 1, 2'b10, 2'b01, 2'b00, 2'd0, 0);
        seg("n_ar1", 2, 0, 1, 1, 2'b11, 2'b00, 2'b00, 2'd1, 0);
        seg("n_ra1", 2, 0, 1, 1, 2'b11, 2'b10, 2'b00, 2'd1, 0);
`endif

        // Reset pulse mid-green of approach 1 with a request pending.
        seg("r_rst", 1, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        seg("r_ar0", 1, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        seg("r_ra0", 2, 0, 1, 0, 2'b11, 2'b01, 2'b00, 2'd0, 0);
        seg("r_g0", 8, 0, 1, 0, 2'b10, 2'b00, 2'b01, 2'd0, 0);
        seg("r_a0", 3, 0, 1, 0, 2'b10, 2'b01, 2'b00, 2'd0, 0);
        seg("r_ar1", 2, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd1, 0);
        seg("r_ra1", 2, 0, 1, 0, 2'b11, 2'b10, 2'b00, 2'd1, 0);
        seg("r_g1", 3, 0, 1, 0, 2'b01, 2'b00, 2'b10, 2'd1, 0);
        seg("r_g1req", 1, 0, 1, 1, 2'b01, 2'b00, 2'b10, 2'd1, 0);
        seg("r_g1", 1, 0, 1, 0, 2'b01, 2'b00, 2'b10, 2'd1, 0);
        seg("r_pulse", 1, 1, 1, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        seg("r_ar0", 1, 0, 1, 0, 2'b11, 2'b00, 2'b00, 2'd0, 0);
        seg("r_ra0_nowalk", 2, 0, 1, 0, 2'b11, 2'b01, 2'b00, 2'd0, 0);

        // Randomised run on three approaches against the slot model.
        for (int i = 0; i < 500; i++) begin
            bit r, e, p;
            r = (i < 2);
            e = ($urandom_range(0, 3) != 0);
            p = ($urandom_range(0, 7) == 0);
            rst3 = r; en3 = e; pr3 = p;
            @(posedge clk);
            #1;
            model_edge(r, e, p);
            chk3();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_junction.md
# traffic_junction

- Parametrised multi-approach traffic-light controller, generalising the single-head red / red+amber / green / amber sequencer to N approaches.
- Serves approaches in round-robin order with programmable per-phase durations and an all-red clearance interval between approaches.
- Adds a freeze input and an optional latched pedestrian-crossing phase.
- Sits directly under the junction top level and drives the lamp outputs.

## Interface
Parameters:
- NUM_APPROACH, 2, number of approaches served, legal 2..4
- ALL_RED_CYC, 2, cycles of all-red clearance before each approach (>=1)
- RED_AMBER_CYC, 2, cycles of red+amber (>=1)
- GREEN_CYC, 8, cycles of green (>=1)
- AMBER_CYC, 3, cycles of amber alone (>=1)
- PED_CYC, 4, cycles of pedestrian walk (>=1)
- CNT_W, 8, phase timer width; every *_CYC parameter must be < 2**CNT_W

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = run; 0 = freeze state, timer and outputs
- ped_req  in  1  pedestrian request, level sampled each edge
- red  out  NUM_APPROACH  red lamp per approach
- amber  out  NUM_APPROACH  amber lamp per approach
- green  out  NUM_APPROACH  green lamp per approach
- active  out  2  index of the approach currently, or next to be, served
- ped_walk  out  1  pedestrian walk lamp

## Operation
- FSM states: ALL_RED, RED_AMBER, GREEN, AMBER, PED_WALK.
- All outputs are registered.
- Each state lasts exactly its *_CYC count of enabled cycles, then advances.
- Sequence for approach k = active: ALL_RED -> RED_AMBER -> GREEN -> AMBER.
- After AMBER: active <= (k+1) mod NUM_APPROACH on entry to ALL_RED.
- Lamp values per state:
  - Served approach: RED_AMBER gives red=1, amber=1; GREEN gives green=1 only; AMBER gives amber=1 only.
  - All non-served approaches show red only.
  - ALL_RED and PED_WALK: every approach shows red only.
- Reset values (on any edge with rst=1, including mid-operation): state ALL_RED with timer loaded, active=0, red=all ones, amber=0, green=0, ped_walk=0, ped_pending=0.
- enable=0: no state, timer or pending-latch change. Outputs hold. ped_req is ignored.
- Pedestrian handling:
  - ped_req=1 at an enabled edge sets ped_pending.
  - At the end of ALL_RED, if ped_pending or ped_req is set: enter PED_WALK and clear pending; otherwise enter RED_AMBER.
  - PED_WALK drives ped_walk=1 with all red, then goes to RED_AMBER for the same active.
  - ped_req during PED_WALK is ignored and not latched.
- Invariants:
  - At most one green bit set.
  - green and amber never set on the same approach.
  - ped_walk=1 implies green=0 and amber=0.

## Timing
- Phase changes are visible on outputs the edge after the timer expires. No combinational input-to-output paths.
- After rst deasserts, all-red is shown for ALL_RED_CYC cycles (counting the cycle after the releasing edge), then approach 0 enters RED_AMBER.
- Per-approach period without pedestrian phase = ALL_RED_CYC+RED_AMBER_CYC+GREEN_CYC+AMBER_CYC. With the defaults this is 15 cycles; the full junction period at N=2 is 30 cycles.
- A pedestrian phase adds exactly PED_CYC cycles to that approach's slot.
- Wrap-around: after the last approach, the next approach served is index 0.

## Configuration
- PED_CROSSING_EN defined: PED_WALK state, ped_pending latch and ped_walk behaviour as above.
- PED_CROSSING_EN undefined:
  - PED_WALK state and latch are absent; ped_req is unused.
  - ped_walk is tied 0.
  - ALL_RED always proceeds to RED_AMBER.

## Test plan
- N=2, defaults: hold rst 3 cycles, release -> red=2'b11, amber=0, green=0, active=0 for 2 cycles; then approach 0 red+amber for 2, green for 8, amber for 3; all-red for 2 with active=1; junction period 30 cycles.
- enable=0 for 5 cycles mid-GREEN of approach 0 -> green[0] held; total green duration is 13 cycles; no other output changes.
- PED_CROSSING_EN, 1-cycle ped_req during approach 0 green -> after amber and 2 all-red cycles, ped_walk=1 with red=2'b11 for 4 cycles, then approach 1 red+amber.
- ped_req high only on the final ALL_RED edge -> PED_WALK entered immediately. Second ped_req during PED_WALK -> no further walk in the next slot.
- rst pulsed for 1 cycle mid-GREEN of approach 1 with a pedestrian request pending -> reset values next cycle, pending cleared, no walk, restart at approach 0.
- NUM_APPROACH=3, random ped_req and enable for 500 cycles -> invariants hold every cycle; round-robin order 0,1,2,0; each phase length matches its parameter.
